// File: rtl/multi_plane_inlier_scorer_if.sv
// Point stream, frame control and per-plane result bundle for multi_plane_inlier_scorer.
interface multi_plane_inlier_scorer_if #(
  parameter int num_planes  = 4,
  parameter int value_bits  = 32,
  parameter int count_width = 16
);
  logic                                        start_i;
  logic [num_planes-1:0][3:0][value_bits-1:0]  planes_i;
  logic [value_bits-1:0]                       threshold_i;
  logic [2:0][value_bits-1:0]                  point_i;
  logic                                        point_valid_i;
  logic                                        point_last_i;
  logic                                        point_ready_o;
  logic                                        result_valid_o;
  logic [num_planes-1:0][value_bits-1:0]       distances_o;
  logic [num_planes-1:0]                       inlier_o;
  logic [num_planes-1:0][count_width-1:0]      counts_o;
  logic                                        busy_o;
  logic                                        done_o;

  modport master (
    output start_i, planes_i, threshold_i, point_i, point_valid_i, point_last_i,
    input  point_ready_o, result_valid_o, distances_o, inlier_o, counts_o, busy_o, done_o
  );

  modport slave (
    input  start_i, planes_i, threshold_i, point_i, point_valid_i, point_last_i,
    output point_ready_o, result_valid_o, distances_o, inlier_o, counts_o, busy_o, done_o
  );
endinterface

// File: rtl/multi_plane_inlier_scorer.sv
// Scores a burst of points against several candidate planes in parallel: pipelined signed
// distance, inclusive inlier test and saturating per-plane inlier counts, framed by start/done.
module multi_plane_inlier_scorer #(
  parameter int num_planes           = 4,
  parameter int value_bits           = 32,
  parameter int frac_bits            = 16,
  parameter int multiply_latency     = value_bits / 8,
  parameter int addition_has_latency = 1,
  parameter int count_width          = 16,
  parameter bit signed_output        = 1'b0
) (
  input logic clock,
  input logic reset_n,
  multi_plane_inlier_scorer_if.slave bus
);

  localparam int lat         = multiply_latency + 2 * addition_has_latency + 1;
  localparam int drain_width = $clog2(lat + 1);

  typedef logic signed [value_bits-1:0] fixed_t;
  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_stream = 2'd1,
    st_drain  = 2'd2,
    st_done   = 2'd3
  } state_t;

  localparam fixed_t                  fixed_max  = {1'b0, {(value_bits-1){1'b1}}};
  localparam fixed_t                  fixed_min  = {1'b1, {(value_bits-1){1'b0}}};
  localparam logic [count_width-1:0]  count_max  = {count_width{1'b1}};
  localparam logic [drain_width-1:0]  drain_load = drain_width'(lat);

  // Full-precision product, arithmetic shift back to the binary point, keep the low word.
  function automatic fixed_t fixed_mul(input fixed_t a, input fixed_t b);
    logic signed [2*value_bits-1:0] wide_a;
    logic signed [2*value_bits-1:0] wide_b;
    logic signed [2*value_bits-1:0] prod;
    wide_a = {{value_bits{a[value_bits-1]}}, a};
    wide_b = {{value_bits{b[value_bits-1]}}, b};
    prod   = (wide_a * wide_b) >>> frac_bits;
    return prod[value_bits-1:0];
  endfunction

  function automatic fixed_t fixed_abs(input fixed_t v);
    fixed_t r;
    if (v == fixed_min) begin
      r = fixed_max;
    end else if (v[value_bits-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t                                 state_r;
  logic                                   ready_r;
  logic                                   busy_r;
  logic                                   done_r;
  logic [drain_width-1:0]                 drain_cnt_r;
  fixed_t                                 normal_r [num_planes][3];
  fixed_t                                 offset_r [num_planes];
  fixed_t                                 threshold_r;
  logic                                   frame_start_s;
  logic                                   accept_s;
  fixed_t                                 prod_r [multiply_latency][num_planes][3];
  logic [multiply_latency-1:0]            prod_valid_r;
  fixed_t                                 sum_a_s [num_planes];
  fixed_t                                 sum_b_s [num_planes];
  fixed_t                                 dist_s [num_planes];
  logic                                   sum_valid_s;
  logic                                   dist_valid_s;
  fixed_t                                 abs_s [num_planes];
  logic [num_planes-1:0]                  inlier_s;
  logic                                   result_valid_r;
  logic [num_planes-1:0][value_bits-1:0]  distances_r;
  logic [num_planes-1:0]                  inlier_r;
  logic [num_planes-1:0][count_width-1:0] counts_r;

  assign frame_start_s = (state_r == st_idle) && bus.start_i;
  assign accept_s      = ready_r && bus.point_valid_i;

  // Frame control: ready only in STREAM, drain for exactly lat cycles, one-cycle done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= st_idle;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drain_cnt_r <= '0;
    end else begin
      case (state_r)
        st_idle: begin
          done_r <= 1'b0;
          if (bus.start_i) begin
            state_r <= st_stream;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        st_stream: begin
          if (accept_s && bus.point_last_i) begin
            state_r     <= st_drain;
            ready_r     <= 1'b0;
            drain_cnt_r <= drain_load;
          end
        end
        st_drain: begin
          drain_cnt_r <= drain_cnt_r - drain_width'(1);
          if (drain_cnt_r == drain_width'(1)) begin
            state_r <= st_done;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        st_done: begin
          state_r <= st_idle;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= st_idle;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Plane set and threshold are captured once per frame and frozen until the next start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      threshold_r <= '0;
      for (int k = 0; k < num_planes; k++) begin
        offset_r[k] <= '0;
        for (int j = 0; j < 3; j++) normal_r[k][j] <= '0;
      end
    end else if (frame_start_s) begin
      threshold_r <= fixed_t'(bus.threshold_i);
      for (int k = 0; k < num_planes; k++) begin
        offset_r[k] <= fixed_t'(bus.planes_i[k][3]);
        for (int j = 0; j < 3; j++) normal_r[k][j] <= fixed_t'(bus.planes_i[k][j]);
      end
    end
  end

  // Multiply pipeline: products formed on accept, then carried through the remaining stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_valid_r <= '0;
      for (int s = 0; s < multiply_latency; s++)
        for (int k = 0; k < num_planes; k++)
          for (int j = 0; j < 3; j++) prod_r[s][k][j] <= '0;
    end else begin
      prod_valid_r[0] <= accept_s;
      for (int k = 0; k < num_planes; k++)
        for (int j = 0; j < 3; j++)
          prod_r[0][k][j] <= fixed_mul(normal_r[k][j], fixed_t'(bus.point_i[j]));
      for (int s = 1; s < multiply_latency; s++) begin
        prod_valid_r[s] <= prod_valid_r[s-1];
        for (int k = 0; k < num_planes; k++)
          for (int j = 0; j < 3; j++) prod_r[s][k][j] <= prod_r[s-1][k][j];
      end
    end
  end

  generate
    if (addition_has_latency != 0) begin : g_add_reg
      // Two registered adder levels: (x+y) and (z-d), then their sum.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          sum_valid_s  <= 1'b0;
          dist_valid_s <= 1'b0;
          for (int k = 0; k < num_planes; k++) begin
            sum_a_s[k] <= '0;
            sum_b_s[k] <= '0;
            dist_s[k]  <= '0;
          end
        end else begin
          sum_valid_s  <= prod_valid_r[multiply_latency-1];
          dist_valid_s <= sum_valid_s;
          for (int k = 0; k < num_planes; k++) begin
            sum_a_s[k] <= prod_r[multiply_latency-1][k][0] + prod_r[multiply_latency-1][k][1];
            sum_b_s[k] <= prod_r[multiply_latency-1][k][2] - offset_r[k];
            dist_s[k]  <= sum_a_s[k] + sum_b_s[k];
          end
        end
      end
    end else begin : g_add_comb
      // Same adder tree without pipeline registers.
      always_comb begin
        sum_valid_s  = prod_valid_r[multiply_latency-1];
        dist_valid_s = sum_valid_s;
        for (int k = 0; k < num_planes; k++) begin
          sum_a_s[k] = prod_r[multiply_latency-1][k][0] + prod_r[multiply_latency-1][k][1];
          sum_b_s[k] = prod_r[multiply_latency-1][k][2] - offset_r[k];
          dist_s[k]  = sum_a_s[k] + sum_b_s[k];
        end
      end
    end
  endgenerate

  // Magnitude with most-negative saturation and the inclusive inlier compare.
  always_comb begin
    for (int k = 0; k < num_planes; k++) begin
      abs_s[k]    = fixed_abs(dist_s[k]);
      inlier_s[k] = (abs_s[k] <= threshold_r);
    end
  end

  // Registered result stage; inlier flags are only meaningful alongside result_valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      result_valid_r <= 1'b0;
      distances_r    <= '0;
      inlier_r       <= '0;
    end else begin
      result_valid_r <= dist_valid_s;
      if (dist_valid_s) begin
        inlier_r <= inlier_s;
        for (int k = 0; k < num_planes; k++)
          distances_r[k] <= (signed_output != 1'b0) ? dist_s[k] : abs_s[k];
      end else begin
        inlier_r <= '0;
      end
    end
  end

  // Saturating per-plane inlier counters, cleared when a frame starts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counts_r <= '0;
    end else if (frame_start_s) begin
      counts_r <= '0;
    end else if (result_valid_r) begin
      for (int k = 0; k < num_planes; k++)
        if (inlier_r[k] && (counts_r[k] != count_max))
          counts_r[k] <= counts_r[k] + count_width'(1);
    end
  end

  assign bus.point_ready_o  = ready_r;
  assign bus.busy_o         = busy_r;
  assign bus.done_o         = done_r;
  assign bus.result_valid_o = result_valid_r;
  assign bus.distances_o    = distances_r;
  assign bus.inlier_o       = inlier_r;
  assign bus.counts_o       = counts_r;

endmodule
